// File: rtl/frame_sched_pkg.sv
// rtl/frame_sched_pkg.sv - shared types and helpers for the frame stream scheduler
package frame_sched_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_rgb444_t;

    typedef enum logic [2:0] {
        MODE_EDGE  = 3'd0,
        MODE_PINK  = 3'd1,
        MODE_GRAY  = 3'd2,
        MODE_SHARP = 3'd3,
        MODE_PASS  = 3'd4
    } mode_e;

    typedef struct packed {
        pixel_rgb444_t pix;
        logic          sop;
        logic          eop;
    } beat_t;

    // A new read may go out only if every word already owed to the buffer still fits,
    // counting the slot freed by a beat leaving this cycle.
    function automatic logic can_issue(input logic [1:0] occupancy,
                                       input logic       in_flight,
                                       input logic       popping);
        return ({1'b0, occupancy} + {2'b00, in_flight}) < (3'd2 + {2'b00, popping});
    endfunction

endpackage

// File: rtl/frame_stream_sched_if.sv
// rtl/frame_stream_sched_if.sv - Avalon-ST pixel source bundle between scheduler and scaler
interface frame_stream_sched_if;

    logic        src_valid;
    logic        src_ready;
    logic [11:0] src_data;
    logic        src_sop;
    logic        src_eop;

    modport master (
        output src_valid,
        output src_data,
        output src_sop,
        output src_eop,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_data,
        input  src_sop,
        input  src_eop,
        output src_ready
    );

endinterface

// File: rtl/frame_stream_sched_skid_buf.sv
// rtl/frame_stream_sched_skid_buf.sv - 2-entry beat FIFO absorbing RAM read latency under backpressure
module stream_skid_buf
    import frame_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       wr_en,
    input  beat_t      wr_beat,
    output logic       out_valid,
    input  logic       out_ready,
    output beat_t      out_beat,
    output logic [1:0] count
);

    beat_t      mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] cnt;
    logic       pop;

    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_beat  = mem[rd_ptr];
    assign count     = cnt;

    // The head entry is never the write target while occupied, so a stalled beat stays put.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_beat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, wr_en} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/frame_stream_sched.sv
// rtl/frame_stream_sched.sv - frame-buffer read sequencer producing an Avalon-ST pixel stream
// Optional frame/stall statistics are built when FRAME_SCHED_STATS_EN is defined.
module frame_stream_sched
    import frame_sched_pkg::*;
#(
    parameter int                H_RES    = 320,
    parameter int                V_RES    = 240,
    parameter int                ADDR_W   = 17,
    parameter int                MODE_W   = 3,
    parameter logic [MODE_W-1:0] MODE_RST = MODE_W'(MODE_PASS)
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    input  logic [MODE_W-1:0]    mode_req,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [11:0]          rd_data,
    frame_stream_sched_if.master src,
    output logic [MODE_W-1:0]    mode_active,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          stall_cnt
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_RES * V_RES - 1);

    beat_t      wr_beat;
    beat_t      head;
    logic       head_valid;
    logic       xfer;
    logic       eop_xfer;
    logic       issue;
    logic [1:0] buf_count;
    logic       rd_pend;
    logic       rd_pend_sop;
    logic       rd_pend_eop;

    assign xfer     = head_valid & src.src_ready;
    assign eop_xfer = xfer & head.eop;
    assign issue    = can_issue(buf_count, rd_pend, xfer);
    assign wr_beat  = {rd_data, rd_pend_sop, rd_pend_eop};

    // rd_addr is also the pixel counter; sop/eop are tagged at issue and ride with the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr     <= '0;
            rd_pend     <= 1'b0;
            rd_pend_sop <= 1'b0;
            rd_pend_eop <= 1'b0;
        end else if (restart) begin
            rd_addr <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= issue;
            if (issue) begin
                rd_pend_sop <= (rd_addr == '0);
                rd_pend_eop <= (rd_addr == LAST_PIX);
                rd_addr     <= (rd_addr == LAST_PIX) ? '0 : rd_addr + 1'b1;
            end
        end
    end

    stream_skid_buf u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (restart),
        .wr_en     (rd_pend),
        .wr_beat   (wr_beat),
        .out_valid (head_valid),
        .out_ready (src.src_ready),
        .out_beat  (head),
        .count     (buf_count)
    );

    assign src.src_valid = head_valid;
    assign src.src_data  = head.pix;
    assign src.src_sop   = head.sop;
    assign src.src_eop   = head.eop;

    // Mode only moves between frames, or when the frame is abandoned anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_active <= MODE_RST;
        end else if (restart || eop_xfer) begin
            mode_active <= mode_req;
        end
    end

`ifdef FRAME_SCHED_STATS_EN
    logic [15:0] frame_q;
    logic [15:0] stall_q;
    logic [15:0] stall_run;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q   <= '0;
            stall_q   <= '0;
            stall_run <= '0;
        end else begin
            if (eop_xfer) begin
                frame_q <= frame_q + 1'b1;
                stall_q <= stall_run;
            end
            if (eop_xfer || restart) begin
                stall_run <= '0;
            end else if (head_valid && !src.src_ready && stall_run != 16'hFFFF) begin
                stall_run <= stall_run + 1'b1;
            end
        end
    end

    assign frame_cnt = frame_q;
    assign stall_cnt = stall_q;
`else
    assign frame_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_stream_sched.sv
// tb/tb_frame_stream_sched.sv - self-checking bench for frame_stream_sched on a reduced 16x12 frame
module tb_frame_stream_sched;

    localparam int H  = 16;
    localparam int V  = 12;
    localparam int N  = H * V;
    localparam int AW = 8;

    typedef struct packed {
        logic [11:0] d;
        logic        sop;
        logic        eop;
    } exp_t;

    typedef struct {
        int         pct;
        int         upto;
        logic [2:0] mreq;
        logic [2:0] exp_mode;
        int         exp_frames;
    } row_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          restart = 1'b0;
    logic [2:0]    mode_req = 3'd4;
    logic [AW-1:0] rd_addr;
    logic [11:0]   rd_data;
    logic [2:0]    mode_active;
    logic [15:0]   frame_cnt;
    logic [15:0]   stall_cnt;

    frame_stream_sched_if sif ();

    frame_stream_sched #(
        .H_RES    (H),
        .V_RES    (V),
        .ADDR_W   (AW),
        .MODE_W   (3),
        .MODE_RST (3'd4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .restart     (restart),
        .mode_req    (mode_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .src         (sif),
        .mode_active (mode_active),
        .frame_cnt   (frame_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pix_of(input int a);
        return 12'(a * 37 + 5);
    endfunction

    always @(posedge clk) rd_data <= pix_of(int'(rd_addr));

    int         checks = 0;
    int         failures = 0;
    int         beats = 0;
    int         frames = 0;
    int         since = 0;
    int         cur_pct = 100;
    logic       seen_valid = 1'b0;
    logic       was_stalled = 1'b0;
    exp_t       held = '0;
    logic [2:0] exp_mode = 3'd4;
    exp_t       sb[$];
    row_t       rows[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_frame();
        for (int a = 0; a < N; a++) sb.push_back({pix_of(a), a == 0, a == N - 1});
    endtask

    task automatic observe();
        exp_t act;
        exp_t e = '0;
        logic xfer;
        act  = {sif.src_data, sif.src_sop, sif.src_eop};
        xfer = sif.src_valid && sif.src_ready && !reset;
        if (was_stalled) begin
            chk("hold_valid", 32'(sif.src_valid), 1);
            chk("hold_beat", 32'(act), 32'(held));
        end
        if (seen_valid && cur_pct >= 100) chk("no_bubble", 32'(sif.src_valid), 1);
        chk("mode_active", 32'(mode_active), 32'(exp_mode));
        if (xfer) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty actual=%0h required=none", act);
            end else begin
                e = sb.pop_front();
                chk("beat", 32'(act), 32'(e));
                if (e.eop) frames++;
            end
            beats++;
            if (sb.size() < N) push_frame();
        end
        if (reset) begin
            exp_mode = 3'd4;
            frames   = 0;
        end else if (restart || (xfer && e.eop)) begin
            exp_mode = mode_req;
        end
        was_stalled = sif.src_valid && !sif.src_ready && !reset && !restart;
        held        = act;
        if (reset || restart) begin
            sb.delete();
            push_frame();
            since      = 0;
            seen_valid = 1'b0;
        end else begin
            since++;
            if (!seen_valid && sif.src_valid) begin
                seen_valid = 1'b1;
                chk("first_valid_latency", since, 3);
            end else if (!seen_valid && since == 12) begin
                checks++;
                failures++;
                $display("FAIL first_valid_timeout actual=none required=valid");
            end
        end
    endtask

    task automatic tick(input int pct, input logic rs, input logic rst_i, input logic rs_eop);
        @(negedge clk);
        cur_pct       = pct;
        sif.src_ready = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
        restart       = rs | (rs_eop & sif.src_valid & sif.src_eop);
        reset         = rst_i;
        observe();
    endtask

    task automatic run_until(input int pct, input int target);
        int guard = 0;
        while (beats < target && guard < 20 * N) begin
            tick(pct, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (beats < target) begin
            failures++;
            $display("FAIL run_until_timeout actual=%0d required=%0d", beats, target);
        end
    endtask

    task automatic chk_frames(input string name, input int exp);
`ifdef FRAME_SCHED_STATS_EN
        chk(name, 32'(frame_cnt), exp);
`else
        chk(name, 32'(frame_cnt), 0);
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_valid"}, 32'(sif.src_valid), 0);
        chk({tag, "_sop"}, 32'(sif.src_sop), 0);
        chk({tag, "_eop"}, 32'(sif.src_eop), 0);
        chk({tag, "_data"}, 32'(sif.src_data), 0);
        chk({tag, "_mode"}, 32'(mode_active), 4);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        int   guard;
        logic fired;

        rows[0] = '{100, N + 1,      3'd4, 3'd4, 1};
        rows[1] = '{50,  3 * N,      3'd4, 3'd4, 3};
        rows[2] = '{100, 3 * N + 50, 3'd4, 3'd4, 3};
        rows[3] = '{60,  4 * N,      3'd2, 3'd2, 4};
        rows[4] = '{100, 4 * N + 10, 3'd2, 3'd2, 4};

        sif.src_ready = 1'b0;
        repeat (3) tick(100, 1'b0, 1'b1, 1'b0);
        tick(100, 1'b0, 1'b0, 1'b0);
        check_reset_vals("init");

        for (int i = 0; i < 5; i++) begin
            mode_req = rows[i].mreq;
            run_until(rows[i].pct, rows[i].upto);
            tick(rows[i].pct, 1'b0, 1'b0, 1'b0);
            chk("row_mode", 32'(mode_active), 32'(rows[i].exp_mode));
            chk_frames("row_frame_cnt", rows[i].exp_frames);
        end

        // restart mid-frame while the sink is stalled
        run_until(100, beats + 90);
        repeat (3) tick(0, 1'b0, 1'b0, 1'b0);
        mode_req = 3'd1;
        tick(0, 1'b1, 1'b0, 1'b0);
        tick(0, 1'b0, 1'b0, 1'b0);
        chk("restart_valid", 32'(sif.src_valid), 0);
        chk("restart_addr", 32'(rd_addr), 0);
        chk("restart_mode", 32'(mode_active), 1);
        run_until(70, beats + N);
        tick(100, 1'b0, 1'b0, 1'b0);
        chk_frames("restart_frame_cnt", 5);

        // restart landing on the eop transfer
        mode_req = 3'd3;
        fired    = 1'b0;
        guard    = 0;
        while (!fired && guard < 3 * N) begin
            tick(100, 1'b0, 1'b0, 1'b1);
            fired = restart;
            guard++;
        end
        chk("restart_eop_fired", 32'(fired), 1);
        tick(100, 1'b0, 1'b0, 1'b0);
        chk("restart_eop_valid", 32'(sif.src_valid), 0);
        chk("restart_eop_mode", 32'(mode_active), 3);
        chk_frames("restart_eop_frame_cnt", 6);
        run_until(100, beats + 20);

        // reset mid-frame with ready low
        repeat (2) tick(0, 1'b0, 1'b0, 1'b0);
        tick(0, 1'b0, 1'b1, 1'b0);
        tick(0, 1'b0, 1'b0, 1'b0);
        check_reset_vals("mid");
        run_until(100, beats + N + 5);

        // three frames, each with ten stalled cycles
        tick(0, 1'b0, 1'b1, 1'b0);
        tick(100, 1'b0, 1'b0, 1'b0);
        base = beats;
        for (int f = 0; f < 3; f++) begin
            run_until(100, base + f * N + 20);
            repeat (10) tick(0, 1'b0, 1'b0, 1'b0);
            run_until(100, base + (f + 1) * N);
        end
        tick(100, 1'b0, 1'b0, 1'b0);
`ifdef FRAME_SCHED_STATS_EN
        chk("stats_frame_cnt", 32'(frame_cnt), 3);
        chk("stats_stall_cnt", 32'(stall_cnt), 10);
`else
        chk("stats_frame_cnt", 32'(frame_cnt), 0);
        chk("stats_stall_cnt", 32'(stall_cnt), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
